// File: rtl/ring_mon_pkg.sv
// rtl/ring_mon_pkg.sv - shared state, fault codes and ring helper functions for ring_phase_monitor
package ring_mon_pkg;

  // Helpers work on a fixed-width container; callers zero-extend and pass the live width.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } ring_state_t;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_ONEHOT = 2'b01;
  localparam logic [1:0] FC_STEP   = 2'b10;

  function automatic logic [MAX_W-1:0] ring_step(input logic [MAX_W-1:0] p, input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if (i < width - 1) r[i] = p[i+1];
    end
    r[width-1] = p[0];
    return r;
  endfunction

  function automatic logic is_onehot(input logic [MAX_W-1:0] v, input int width);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width && v[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_W-1:0] v, input int width);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width && v[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_phase_monitor_enc.sv
// rtl/ring_phase_monitor_enc.sv - ring_onehot_enc: combinational one-hot check and binary encode
module ring_onehot_enc
  import ring_mon_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ring_in,
  output logic             onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    onehot = is_onehot(MAX_W'(ring_in), WIDTH);
    idx    = IDX_W'(onehot_to_idx(MAX_W'(ring_in), WIDTH));
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - one-hot ring phase tracker with lock/fault FSM
// Optional err_count output under RING_PHASE_MONITOR_STATS_EN.
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = $clog2(WIDTH),
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_valid,
  input  logic             clear_fault,
  output logic [IDX_W-1:0] phase_idx,
  output logic             phase_valid,
  output logic [REV_W-1:0] rev_count,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
`ifdef RING_PHASE_MONITOR_STATS_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int GC_W = $clog2(LOCK_CNT + 1);

  ring_state_t      state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [GC_W-1:0]  good_cnt;
  logic             in_onehot;
  logic [IDX_W-1:0] in_idx;
  logic             step_ok, good, lock_hit;

  ring_onehot_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .ring_in (ring_in),
    .onehot  (in_onehot),
    .idx     (in_idx)
  );

  assign step_ok  = (MAX_W'(ring_in) == ring_step(MAX_W'(prev), WIDTH));
  assign good     = ring_valid && in_onehot && step_ok;
  // Lock on the LOCK_CNT-th consecutive good step, i.e. when the pre-increment count hits LOCK_CNT-1.
  assign lock_hit = (good_cnt == GC_W'(LOCK_CNT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear_fault) begin
      state_nxt = IDLE;
    end else if (ring_valid) begin
      case (state)
        IDLE:    if (in_onehot) state_nxt = LOCKING;
        LOCKING: begin
          if (!in_onehot)           state_nxt = IDLE;
          else if (good && lock_hit) state_nxt = LOCKED;
        end
        LOCKED:  if (!good) state_nxt = FAULT;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
    fault  = (state == FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev        <= '0;
      good_cnt    <= '0;
      rev_count   <= '0;
      phase_idx   <= '0;
      phase_valid <= 1'b0;
      fault_code  <= FC_NONE;
    end else begin
      phase_valid <= 1'b0;
      if (clear_fault) begin
        prev       <= '0;
        good_cnt   <= '0;
        rev_count  <= '0;
        fault_code <= FC_NONE;
      end else if (ring_valid) begin
        case (state)
          IDLE: if (in_onehot) begin
            prev     <= ring_in;
            good_cnt <= '0;
          end
          LOCKING: if (in_onehot) begin
            prev     <= ring_in;
            good_cnt <= step_ok ? good_cnt + 1'b1 : '0;
          end
          LOCKED: begin
            if (good) begin
              prev        <= ring_in;
              phase_idx   <= in_idx;
              phase_valid <= 1'b1;
              if (prev[0]) rev_count <= rev_count + 1'b1;
            end else begin
              fault_code <= in_onehot ? FC_STEP : FC_ONEHOT;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RING_PHASE_MONITOR_STATS_EN
  // Survives clear_fault so repeated fault/clear cycles remain visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (state == LOCKED && state_nxt == FAULT && err_count != 8'hFF) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - randomized self-checking bench for ring_phase_monitor
module tb_ring_phase_monitor;
  localparam int WIDTH = 4, IDX_W = 2, REV_W = 8, LOCK_CNT = 2;
  localparam int PW = 5 + IDX_W + REV_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [WIDTH-1:0] ring_in = '0;
  logic ring_valid = 1'b0, clear_fault = 1'b0;
  logic [IDX_W-1:0] phase_idx;
  logic phase_valid, locked, fault;
  logic [REV_W-1:0] rev_count;
  logic [1:0] fault_code;
`ifdef RING_PHASE_MONITOR_STATS_EN
  logic [7:0] err_count;
`endif

  ring_phase_monitor #(.WIDTH(WIDTH), .IDX_W(IDX_W), .REV_W(REV_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .reset(reset), .ring_in(ring_in), .ring_valid(ring_valid),
    .clear_fault(clear_fault), .phase_idx(phase_idx), .phase_valid(phase_valid),
    .rev_count(rev_count), .locked(locked), .fault(fault), .fault_code(fault_code)
`ifdef RING_PHASE_MONITOR_STATS_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  // Reference model: phase tracked as an integer index, steps as index-1 modulo WIDTH.
  bit m_locked, m_fault, m_track, m_pv;
  int m_prev, m_run, m_code, m_pidx, m_rev, m_err;

  function automatic int idx_of(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_fault = 0; m_track = 0; m_pv = 0;
    m_prev = -1; m_run = 0; m_code = 0; m_pidx = 0; m_rev = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [WIDTH-1:0] d, input bit clr);
    bit oh, gd;
    int ix;
    m_pv = 0;
    if (clr) begin
      m_locked = 0; m_fault = 0; m_track = 0; m_code = 0; m_rev = 0; m_run = 0; m_prev = -1;
      return;
    end
    if (!v) return;
    oh = ($countones(d) == 1);
    ix = idx_of(d);
    gd = oh && m_prev >= 0 && ix == (m_prev + WIDTH - 1) % WIDTH;
    if (m_fault) return;
    if (m_locked) begin
      if (gd) begin
        if (m_prev == 0) m_rev = (m_rev + 1) % (1 << REV_W);
        m_pidx = ix; m_pv = 1; m_prev = ix;
      end else begin
        m_locked = 0; m_fault = 1; m_code = oh ? 2 : 1;
        if (m_err < 255) m_err++;
      end
    end else if (m_track) begin
      if (!oh) m_track = 0;
      else begin
        if (gd) m_run++; else m_run = 0;
        m_prev = ix;
        if (m_run == LOCK_CNT) begin m_locked = 1; m_track = 0; end
      end
    end else if (oh) begin
      m_track = 1; m_run = 0; m_prev = ix;
    end
  endfunction

  function automatic logic [PW-1:0] expv();
    logic [1:0] c;
    logic [IDX_W-1:0] p;
    logic [REV_W-1:0] r;
    c = m_code[1:0]; p = m_pidx[IDX_W-1:0]; r = m_rev[REV_W-1:0];
    return {m_locked, m_fault, c, p, m_pv, r};
  endfunction

  logic [PW-1:0] gotv;
  assign gotv = {locked, fault, fault_code, phase_idx, phase_valid, rev_count};

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit clr);
    ring_valid = v; ring_in = d; clear_fault = clr;
    @(posedge clk);
    model_step(v, d, clr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #7;
    checks++;
    if (gotv !== '0) $display("FAIL reset_outputs got=%h exp=0", gotv); else passed++;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lock_track();
    logic [WIDTH-1:0] seq [6];
    seq = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      drive(1, seq[i], 0);
      checks++;
      if (gotv !== expv()) $display("FAIL lock_track[%0d] got=%h exp=%h", i, gotv, expv()); else passed++;
      if (i == 1) begin
        checks++;
        if (locked !== 1'b0) $display("FAIL early_lock got=%b exp=0", locked); else passed++;
      end
      if (i == 2) begin
        checks++;
        if (locked !== 1'b1) $display("FAIL lock_after_0100 got=%b exp=1", locked); else passed++;
      end
      if (i == 4) begin
        checks++;
        if ({phase_idx, phase_valid} !== 3'b001) $display("FAIL idx0 got=%b exp=001", {phase_idx, phase_valid}); else passed++;
      end
    end
    checks++;
    if (rev_count !== 8'd1) $display("FAIL rev_one got=%0d exp=1", rev_count); else passed++;
  endtask

  task automatic test_onehot_fault();
    drive(1, 4'b0110, 0);
    checks++;
    if ({fault, locked, fault_code, phase_idx, phase_valid} !== 7'b1001_110)
      $display("FAIL onehot_fault got=%b exp=1001110", {fault, locked, fault_code, phase_idx, phase_valid});
    else passed++;
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'($urandom), 0);
      checks++;
      if (gotv !== expv()) $display("FAIL fault_hold[%0d] got=%h exp=%h", i, gotv, expv()); else passed++;
    end
  endtask

  task automatic test_bad_step();
    logic [WIDTH-1:0] seq [4];
    seq = '{4'b0001, 4'b1000, 4'b0100, 4'b0100};
    drive(1, 4'($urandom), 1);
    for (int i = 0; i < 4; i++) drive(1, seq[i], 0);
    checks++;
    if ({fault, fault_code} !== 3'b110) $display("FAIL bad_step got=%b exp=110", {fault, fault_code}); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'b0010 >> (i % 2), 0);
      checks++;
      if (gotv !== expv()) $display("FAIL bad_step_hold[%0d] got=%h exp=%h", i, gotv, expv()); else passed++;
    end
    drive(0, 4'b0000, 1);
    checks++;
    if ({locked, fault, fault_code, rev_count} !== 12'h0) $display("FAIL clear got=%h exp=0", {locked, fault, fault_code, rev_count}); else passed++;
  endtask

  task automatic test_gaps_wrap();
    logic [WIDTH-1:0] cur;
    int bad;
    bad = 0;
    cur = 4'b0001;
    drive(1, cur, 0);
    for (int i = 0; i < 2; i++) begin cur = {cur[0], cur[WIDTH-1:1]}; drive(1, cur, 0); end
    for (int k = 0; k < 600; k++) begin
      if (k % 2 == 0) begin cur = {cur[0], cur[WIDTH-1:1]}; drive(1, cur, 0); end
      else drive(0, 4'($urandom), 0);
      if (gotv !== expv()) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL gaps_model got=%0d_bad_cycles exp=0", bad); else passed++;
    checks++;
    if ({fault, rev_count} !== {1'b0, 8'd75}) $display("FAIL gaps_rev got=%0d,%0d exp=0,75", fault, rev_count); else passed++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] cur, d;
    bit v, clr;
    int s, bad;
    bad = 0;
    cur = 4'b0001;
    for (int k = 0; k < 1500; k++) begin
      clr = ($urandom_range(99) < 3);
      v = ($urandom_range(9) < 8);
      s = $urandom_range(99);
      if (s < 85) d = {cur[0], cur[WIDTH-1:1]};
      else if (s < 92) d = cur;
      else d = 4'($urandom);
      if (v && $countones(d) == 1) cur = d;
      drive(v, d, clr);
      if (gotv !== expv()) begin
        bad++;
        if (bad <= 3) $display("FAIL random[%0d] got=%h exp=%h", k, gotv, expv());
      end
    end
    checks++;
    if (bad != 0) $display("FAIL random_total got=%0d exp=0", bad); else passed++;
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] seq [3];
    seq = '{4'b0010, 4'b0001, 4'b1000};
    drive(1, 4'b0001, 1);
    drive(1, 4'b0001, 0);
    drive(1, 4'b1000, 0);
    drive(1, 4'b0100, 0);
    drive(1, 4'b0010, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (gotv !== '0) $display("FAIL async_reset got=%h exp=0", gotv); else passed++;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, seq[i], 0);
      checks++;
      if (locked !== (i == 2)) $display("FAIL relock[%0d] got=%b exp=%b", i, locked, (i == 2)); else passed++;
    end
  endtask

`ifdef RING_PHASE_MONITOR_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1'b0;
    #1 model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(1, 4'b0001, 0);
      drive(1, 4'b1000, 0);
      drive(1, 4'b0100, 0);
      drive(1, (n == 1) ? 4'b0000 : 4'b0100, 0);
      drive(0, 4'b0000, 1);
    end
    checks++;
    if (err_count !== 8'd3) $display("FAIL err_count got=%0d exp=3", err_count); else passed++;
    checks++;
    if (err_count !== m_err[7:0]) $display("FAIL err_model got=%0d exp=%0d", err_count, m_err); else passed++;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_lock_track();
    test_onehot_fault();
    test_bad_step();
    test_gaps_wrap();
    test_random();
    test_async_reset();
`ifdef RING_PHASE_MONITOR_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Sits directly downstream of the one-hot ring counter and consumes its WIDTH-bit count vector every cycle.
- Checks that the vector is one-hot and advances by exactly one rotation step per valid sample. The step rotates toward the LSB, and bit 0 wraps into bit WIDTH-1.
- Produces a registered binary phase index, a revolution counter, lock status and a sticky fault indication for downstream sequencing logic.

Parameters:
- WIDTH, 4, ring width in bits; minimum 2.
- IDX_W, $clog2(WIDTH), width of phase_idx.
- REV_W, 8, width of the revolution counter.
- LOCK_CNT, 2, number of consecutive correct steps required to enter LOCKED; minimum 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ring_in  in  WIDTH  ring counter output vector.
- ring_valid  in  1  ring_in holds a new sample this cycle.
- clear_fault  in  1  synchronous clear of FAULT, fault_code and rev_count.
- phase_idx  out  IDX_W  binary index of the set bit of the last accepted sample.
- phase_valid  out  1  one-cycle pulse, phase_idx updated.
- rev_count  out  REV_W  completed revolutions while LOCKED.
- locked  out  1  state == LOCKED.
- fault  out  1  state == FAULT.
- fault_code  out  2  00 none, 01 not one-hot, 10 bad step.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset is low, every output is 0, the state is IDLE, and prev, good_cnt and rev_count are 0.
- Definitions:
  - onehot(v): exactly one bit of v set.
  - step(p) = {p[0], p[WIDTH-1:1]}.
  - A sample is "good" when ring_valid=1, onehot(ring_in)=1 and ring_in == step(prev).
- ring_valid=0: no state, prev, counter or output change, except that phase_valid returns to 0.
- State IDLE:
  - Valid one-hot sample -> prev <= ring_in, good_cnt <= 0, go to LOCKING.
  - Valid non-one-hot sample -> ignored, stay in IDLE.
- State LOCKING:
  - Good sample -> good_cnt++. When good_cnt reaches LOCK_CNT-1 on this sample, go to LOCKED.
  - Valid one-hot sample with a wrong step -> good_cnt <= 0, stay in LOCKING.
  - Valid non-one-hot sample -> go to IDLE.
  - prev <= ring_in on every valid one-hot sample.
- State LOCKED:
  - Good sample -> prev <= ring_in, phase_idx <= index of ring_in, phase_valid pulses the next cycle (1-cycle latency).
  - Revolution count: if prev[0]=1 and the sample is good, rev_count++. It wraps modulo 2^REV_W.
  - Valid non-one-hot sample (all zero or multiple bits set) -> FAULT, fault_code=01.
  - Valid one-hot sample with a wrong step, including a repeated value -> FAULT, fault_code=10.
- State FAULT:
  - All samples ignored; phase_idx and rev_count are held; fault_code is sticky.
- clear_fault:
  - Highest priority after reset, in any state.
  - Next state IDLE; fault_code, rev_count, good_cnt and prev cleared.
  - The sample presented in the same cycle is discarded.
- phase_valid is asserted only from LOCKED. It is never asserted in the cycle after the transition into FAULT.
- locked and fault are registered state decodes. They change in the cycle after the triggering sample.
- Reset asserted mid-operation: immediate asynchronous return to the reset values above, regardless of state.

Optional Feature:
- Macro: RING_PHASE_MONITOR_STATS_EN.
- Defined:
  - Adds output err_count (8 bits).
  - err_count increments on every LOCKED->FAULT transition and saturates at 255.
  - Cleared only by reset; not cleared by clear_fault.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Package ring_mon_pkg holds:
  - the state enum (IDLE, LOCKING, LOCKED, FAULT);
  - the fault_code constants (FC_NONE, FC_ONEHOT, FC_STEP);
  - functions ring_step(), is_onehot() and onehot_to_idx(), all parameterised by WIDTH.
- One natural sub-module: ring_onehot_enc. It is purely combinational: one-hot check plus binary encode of ring_in. It is instantiated once in ring_phase_monitor.

Test Plan (WIDTH=4, LOCK_CNT=2, REV_W=8):
- Lock and track: reset release, then valid samples 0001, 1000, 0100, 0010, 0001 on consecutive cycles.
  - locked=1 the cycle after 0100.
  - phase_idx then goes 1, 0, with a phase_valid pulse each.
  - rev_count=1 after 1000 follows 0001 while LOCKED.
- Non-one-hot fault: while LOCKED, present 0110 -> fault=1, locked=0, fault_code=01; phase_idx held.
- Bad-step fault: while LOCKED with prev=0100, present 0100 again -> fault_code=10. Later samples are ignored until clear_fault=1, after which state=IDLE and rev_count=0.
- Valid gaps and wrap: while LOCKED, ring_valid toggles 1/0 across 300 good samples.
  - No fault.
  - rev_count = (300 div 4) mod 256, with phase_valid only after valid cycles.
- Async reset mid-LOCKED: drive reset low between clock edges -> all outputs 0 immediately, without waiting for a clock edge; relock requires LOCK_CNT good steps again.
- With RING_PHASE_MONITOR_STATS_EN: apply 3 fault/clear cycles -> err_count=3. clear_fault does not reset it.
